memory_port_arbiter: RTL
========================

# memory_port_arbiter

Shares the single-ported data memory, sequenced by `memory_control_fsm`, between the instruction-fetch unit and the load/store unit. It picks one requester, issues a one-cycle `load`/`store` command with muxed address, data and word type to the memory controller, and waits for completion. It then returns a one-cycle acknowledge with captured read data to the winning requester. It sits between the core pipeline and `memory_control_fsm`.

## Interface
- `ADDR_W`, 16: byte address width.
- `MAX_LS_STREAK`, 4: consecutive load/store grants allowed while a fetch is waiting (1..15).
- `TIMEOUT`, 63: wait cycles before a transaction is aborted (1..255).

- `clk`  in  1  clock, rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `if_req`  in  1  fetch request; held until `if_ack`.
- `if_addr`  in  ADDR_W  fetch address.
- `if_ack`  out  1  one-cycle completion pulse to fetch.
- `if_rdata`  out  32  fetched word; valid with `if_ack`, then held.
- `ls_load`, `ls_store`  in  1 each  data request; held until `ls_ack`.
- `ls_addr`  in  ADDR_W  data address.
- `ls_wdata`  in  32  store data.
- `ls_word_type`  in  2  00 byte, 01 halfword, 10 word, 11 reserved (treated as word).
- `ls_signed`  in  1  sign-extend loaded sub-word.
- `ls_ack`  out  1  one-cycle completion pulse to load/store.
- `ls_rdata`  out  32  load data; valid with `ls_ack`, then held.
- `mem_load`, `mem_store`  out  1 each  command strobes to the memory controller.
- `mem_word_type`  out  2  word type to the controller.
- `mem_is_signed`  out  1  signedness to the controller.
- `mem_addr`  out  ADDR_W  address to the controller.
- `mem_wdata`  out  32  write data to the controller.
- `mem_busy`  in  1  controller busy.
- `mem_output_valid`  in  1  load data valid.
- `mem_write_ready`  in  1  store complete.
- `mem_rdata`  in  32  load data from the memory datapath.
- `err_timeout`  out  1  one-cycle pulse when a transaction is aborted.

## Operation
- States: IDLE, ISSUE, WAIT, ACK.
- **IDLE**
  - Arbitration happens only here, and only when `mem_busy`=0.
  - If only one requester is active, it wins.
  - If both are active, load/store wins unless `streak`==`MAX_LS_STREAK`; in that case fetch wins.
  - On a win, latch the winner (`owner`), the command, address, wdata, word type and signed into registers, then go to ISSUE.
- **ISSUE** (exactly one cycle)
  - Assert `mem_load` or `mem_store` for this cycle only. The `mem_*` buses carry the latched values.
  - Go to WAIT. The watchdog counter is cleared on entry to WAIT.
- **WAIT**
  - The `mem_*` buses stay stable.
  - Completion is `mem_output_valid` for a load or `mem_write_ready` for a store. On completion, capture `mem_rdata` into the owner's rdata register and go to ACK.
  - If the watchdog reaches `TIMEOUT` without completion: pulse `err_timeout`, do not ack, return to IDLE. The requester retries by keeping its request high.
- **ACK**
  - Pulse `if_ack` or `ls_ack` for one cycle, then go to IDLE.
- Fetch commands are always word type 10, unsigned load; `mem_wdata` is 0 for fetch.
- Data command: `ls_store`=1 gives a store. If both `ls_load` and `ls_store` are 1, the request is a load.
- Streak counter (4-bit):
  - Incremented on a load/store grant while `if_req`=1, saturating at `MAX_LS_STREAK`.
  - Cleared on a fetch grant, or on any IDLE cycle with `if_req`=0.
- A requester that drops its request mid-transaction still gets the transaction completed and acked. A requester asserting again in the ACK cycle is treated as a new request in the following IDLE.

## Timing
- Reset value of every output is 0. On reset, the state goes to IDLE and `streak`, watchdog, `owner` and the rdata registers are cleared.
- Reset mid-transaction aborts it immediately: no ack, no `err_timeout`.
- Latency:
  - Request visible in IDLE at cycle t puts the strobe on `mem_*` at t+1.
  - Completion at cycle c gives the ack at c+1.
  - The next arbitration happens at c+2.
- Minimum request-to-ack is 4 cycles, assuming completion in the first WAIT cycle.
- All outputs are driven from registers; no combinational path from any input to any output.
- `mem_busy`=1 in IDLE stalls arbitration. Requests stay pending; `streak` is unchanged.
- Completion and watchdog expiry in the same cycle: completion wins and no error is raised.

## Test plan
- Fetch alone, `if_addr`=0x0040, `mem_output_valid` 3 cycles after the strobe with `mem_rdata`=0xE3A01005 -> one-cycle `mem_load`, `mem_word_type`=10; `if_ack` with `if_rdata`=0xE3A01005 on the cycle after valid.
- Byte store, `ls_store`, `ls_addr`=0x0103, `ls_wdata`=0x000000AB, `ls_word_type`=00 -> `mem_store` pulse with addr 0x0103, wdata 0xAB, type 00; `ls_ack` the cycle after `mem_write_ready`; `if_ack` stays 0.
- `if_req` and `ls_load` held continuously, `MAX_LS_STREAK`=4 -> grant order LS, LS, LS, LS, IF, LS…; `streak` never exceeds 4.
- `mem_busy`=1 for 5 cycles while `ls_load`=1 -> no strobe until `mem_busy` falls; strobe exactly one cycle after the first idle cycle with `mem_busy`=0.
- No completion for `TIMEOUT`=63 cycles -> `err_timeout` pulse, no ack, IDLE; a held request is reissued.
- Reset asserted during WAIT -> all outputs 0 at once; after release, a new request completes normally with no stale ack.

Source files
------------

// File: rtl/memory_port_arbiter.sv
// memory_port_arbiter: shares the single-ported data memory between the
// instruction-fetch unit and the load/store unit. One requester is granted
// at a time. It gets a one-cycle command strobe, a watchdog-guarded wait for
// completion, and a one-cycle acknowledge carrying the captured read data.
module memory_port_arbiter #(
  parameter int ADDR_W        = 16,
  parameter int MAX_LS_STREAK = 4,
  parameter int TIMEOUT       = 63
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ack,
  output logic [31:0]       if_rdata,
  input  logic              ls_load,
  input  logic              ls_store,
  input  logic [ADDR_W-1:0] ls_addr,
  input  logic [31:0]       ls_wdata,
  input  logic [1:0]        ls_word_type,
  input  logic              ls_signed,
  output logic              ls_ack,
  output logic [31:0]       ls_rdata,
  output logic              mem_load,
  output logic              mem_store,
  output logic [1:0]        mem_word_type,
  output logic              mem_is_signed,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic              mem_busy,
  input  logic              mem_output_valid,
  input  logic              mem_write_ready,
  input  logic [31:0]       mem_rdata,
  output logic              err_timeout
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, ACK} state_t;

  localparam logic [3:0] MaxStreak   = 4'(MAX_LS_STREAK);
  localparam logic [7:0] TimeoutLast = 8'(TIMEOUT - 1);

  state_t              r_state;
  logic                r_ownerIf;
  logic                r_isStore;
  logic [3:0]          r_streak;
  logic [7:0]          r_wdog;
  logic                r_memLoad;
  logic                r_memStore;
  logic [1:0]          r_wordType;
  logic                r_isSigned;
  logic [ADDR_W-1:0]   r_addr;
  logic [31:0]         r_wdata;
  logic                r_ifAck;
  logic                r_lsAck;
  logic [31:0]         r_ifRdata;
  logic [31:0]         r_lsRdata;
  logic                r_errTimeout;

  logic                w_lsReq;
  logic                w_grantLs;
  logic                w_grantIf;
  logic                w_lsIsStore;
  logic [1:0]          w_lsType;
  logic                w_done;
  logic                w_expired;

  // Load/store has priority unless it has already won MAX_LS_STREAK times while
  // a fetch waited. A data request with both load and store set counts as a load.
  // The reserved word type 11 is sent to the controller as a plain word.
  assign w_lsReq     = ls_load | ls_store;
  assign w_grantLs   = w_lsReq && (!if_req || (r_streak != MaxStreak));
  assign w_grantIf   = if_req && !w_grantLs;
  assign w_lsIsStore = ls_store && !ls_load;
  assign w_lsType    = (ls_word_type == 2'b11) ? 2'b10 : ls_word_type;
  assign w_done      = r_isStore ? mem_write_ready : mem_output_valid;
  assign w_expired   = (r_wdog == TimeoutLast);

  // Single sequencer: arbitration, command latch, wait/watchdog, and pulse outputs.
  // Pulse outputs are cleared every cycle unless a branch below sets them again.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= IDLE;
      r_ownerIf    <= 1'b0;
      r_isStore    <= 1'b0;
      r_streak     <= 4'd0;
      r_wdog       <= 8'd0;
      r_memLoad    <= 1'b0;
      r_memStore   <= 1'b0;
      r_wordType   <= 2'b00;
      r_isSigned   <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= 32'd0;
      r_ifAck      <= 1'b0;
      r_lsAck      <= 1'b0;
      r_ifRdata    <= 32'd0;
      r_lsRdata    <= 32'd0;
      r_errTimeout <= 1'b0;
    end else begin
      r_memLoad    <= 1'b0;
      r_memStore   <= 1'b0;
      r_ifAck      <= 1'b0;
      r_lsAck      <= 1'b0;
      r_errTimeout <= 1'b0;
      case (r_state)
        IDLE: begin
          if (!if_req) begin
            r_streak <= 4'd0;
          end
          if (!mem_busy && (w_grantLs || w_grantIf)) begin
            if (w_grantLs) begin
              r_ownerIf  <= 1'b0;
              r_isStore  <= w_lsIsStore;
              r_memLoad  <= !w_lsIsStore;
              r_memStore <= w_lsIsStore;
              r_addr     <= ls_addr;
              r_wdata    <= ls_wdata;
              r_wordType <= w_lsType;
              r_isSigned <= ls_signed;
              if (if_req && (r_streak != MaxStreak)) begin
                r_streak <= r_streak + 4'd1;
              end
            end else begin
              r_ownerIf  <= 1'b1;
              r_isStore  <= 1'b0;
              r_memLoad  <= 1'b1;
              r_addr     <= if_addr;
              r_wdata    <= 32'd0;
              r_wordType <= 2'b10;
              r_isSigned <= 1'b0;
              r_streak   <= 4'd0;
            end
            r_state <= ISSUE;
          end
        end
        ISSUE: begin
          r_wdog  <= 8'd0;
          r_state <= WAIT;
        end
        WAIT: begin
          if (w_done) begin
            if (r_ownerIf) begin
              r_ifRdata <= mem_rdata;
              r_ifAck   <= 1'b1;
            end else begin
              r_lsRdata <= mem_rdata;
              r_lsAck   <= 1'b1;
            end
            r_state <= ACK;
          end else if (w_expired) begin
            r_errTimeout <= 1'b1;
            r_state      <= IDLE;
          end else begin
            r_wdog <= r_wdog + 8'd1;
          end
        end
        ACK: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign if_ack        = r_ifAck;
  assign if_rdata      = r_ifRdata;
  assign ls_ack        = r_lsAck;
  assign ls_rdata      = r_lsRdata;
  assign mem_load      = r_memLoad;
  assign mem_store     = r_memStore;
  assign mem_word_type = r_wordType;
  assign mem_is_signed = r_isSigned;
  assign mem_addr      = r_addr;
  assign mem_wdata     = r_wdata;
  assign err_timeout   = r_errTimeout;

endmodule
